apb_gpio_v2: RTL and testbench



---
 rtl/apb_gpio_v2_if.sv | 20 ++
 rtl/apb_gpio_v2.sv | 162 ++++++++++++++++
 tb/tb_apb_gpio_v2.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_v2_if.sv
// APB bus bundle for the apb_gpio_v2 slave.
interface apb_gpio_v2_if;
    logic [4:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_gpio_v2.sv
// APB GPIO slave: direction/output regs, atomic set/clear, synchronised inputs,
// per-pin edge interrupts. Optional input debounce filter under APB_GPIO_DEBOUNCE_EN.
module apb_gpio_v2 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_gpio_v2_if.slave    apb,
    inout  wire [WIDTH-1:0] gpio,
    output logic            irq
);

    typedef enum logic [2:0] {
        A_CR  = 3'd0,
        A_IDR = 3'd1,
        A_ODR = 3'd2,
        A_SET = 3'd3,
        A_CLR = 3'd4,
        A_IER = 3'd5,
        A_IEF = 3'd6,
        A_ISR = 3'd7
    } reg_e;

    logic [WIDTH-1:0] cr_q, cr_d;
    logic [WIDTH-1:0] odr_q, odr_d;
    logic [WIDTH-1:0] ier_q, ier_d;
    logic [WIDTH-1:0] ief_q, ief_d;
    logic [WIDTH-1:0] isr_q, isr_d;
    logic [WIDTH-1:0] prev_q;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q;
    logic             irq_q;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] idr;
    logic [WIDTH-1:0] wdata, w1c, rise, fall;
    logic [31:0]      rdata;
    logic             access, wr;
    reg_e             sel;
    logic             unused_bits;

    assign sel         = reg_e'(apb.PADDR[4:2]);
    assign access      = apb.PSEL & apb.PENABLE & ~pready_q;
    assign wr          = access & apb.PWRITE;
    assign wdata       = apb.PWDATA[WIDTH-1:0];
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign gpio[g] = cr_q[g] ? odr_q[g] : 1'bz;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef APB_GPIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // Counter runs only while the synchronised pin disagrees with the filtered value.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync_q[SYNC_STAGES-1][i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    filt_q[i] <= sync_q[SYNC_STAGES-1][i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign idr = filt_q;
`else
    localparam int unsigned unused_deb_cycles = DEB_CYCLES;

    assign idr = sync_q[SYNC_STAGES-1];
`endif

    assign rise = idr & ~prev_q;
    assign fall = ~idr & prev_q;

    always_comb begin
        cr_d  = cr_q;
        odr_d = odr_q;
        ier_d = ier_q;
        ief_d = ief_q;
        w1c   = '0;
        if (wr) begin
            case (sel)
                A_CR:    cr_d  = wdata;
                A_ODR:   odr_d = wdata;
                A_SET:   odr_d = odr_q | wdata;
                A_CLR:   odr_d = odr_q & ~wdata;
                A_IER:   ier_d = wdata;
                A_IEF:   ief_d = wdata;
                A_ISR:   w1c   = wdata;
                default: ;
            endcase
        end
        // New edges are OR-ed in after the clear so a same-cycle event survives.
        isr_d = (isr_q & ~w1c) | (rise & ier_q) | (fall & ief_q);
    end

    always_comb begin
        rdata = '0;
        case (sel)
            A_CR:    rdata[WIDTH-1:0] = cr_q;
            A_IDR:   rdata[WIDTH-1:0] = idr;
            A_ODR:   rdata[WIDTH-1:0] = odr_q;
            A_IER:   rdata[WIDTH-1:0] = ier_q;
            A_IEF:   rdata[WIDTH-1:0] = ief_q;
            A_ISR:   rdata[WIDTH-1:0] = isr_q;
            default: rdata = '0;
        endcase
        prdata_d = (access & ~apb.PWRITE) ? rdata : prdata_q;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            cr_q     <= '0;
            odr_q    <= '0;
            ier_q    <= '0;
            ief_q    <= '0;
            isr_q    <= '0;
            prev_q   <= '0;
            prdata_q <= '0;
            pready_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cr_q     <= cr_d;
            odr_q    <= odr_d;
            ier_q    <= ier_d;
            ief_q    <= ief_d;
            isr_q    <= isr_d;
            prev_q   <= idr;
            prdata_q <= prdata_d;
            pready_q <= access;
            irq_q    <= |isr_q;
        end
    end

    assign apb.PRDATA = prdata_q;
    assign apb.PREADY = pready_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_apb_gpio_v2.sv
// Directed scoreboard bench for apb_gpio_v2 (WIDTH=8, SYNC_STAGES=2, DEB_CYCLES=4).
module tb_apb_gpio_v2;

`ifdef APB_GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif

    localparam logic [2:0] R_CR  = 3'd0;
    localparam logic [2:0] R_IDR = 3'd1;
    localparam logic [2:0] R_ODR = 3'd2;
    localparam logic [2:0] R_SET = 3'd3;
    localparam logic [2:0] R_CLR = 3'd4;
    localparam logic [2:0] R_IER = 3'd5;
    localparam logic [2:0] R_IEF = 3'd6;
    localparam logic [2:0] R_ISR = 3'd7;

    logic PCLK = 1'b0;
    logic PRESET;
    logic irq;
    wire  [7:0] gpio;
    logic [7:0] tb_val;
    logic [7:0] tb_oe;

    always #5 PCLK = ~PCLK;

    apb_gpio_v2_if bus ();

    for (genvar g = 0; g < 8; g++) begin : g_drv
        assign gpio[g] = tb_oe[g] ? tb_val[g] : 1'bz;
    end

    apb_gpio_v2 #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEB_CYCLES(4)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .apb(bus),
        .gpio(gpio),
        .irq(irq)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // Starts at a negedge; returns at the negedge where PREADY is seen (or one later if chk).
    task automatic xfer(input logic w, input logic [2:0] idx, input logic [31:0] wd,
                        input bit chk, input string tag);
        bit seen;
        logic [31:0] expv;
        seen = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = w;
        bus.PADDR   = {idx, 2'b00};
        bus.PWDATA  = wd;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        if (chk) check({tag, "_wait"}, {31'b0, bus.PREADY}, 32'h0);
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge PCLK);
            if (bus.PREADY === 1'b1) seen = 1'b1;
        end
        check({tag, "_ready"}, {31'b0, bus.PREADY}, 32'h1);
        if (!w) begin
            expv = exp_q.pop_front();
            check(tag, bus.PRDATA, expv);
        end
        if (chk) begin
            @(negedge PCLK);
            check({tag, "_pulse"}, {31'b0, bus.PREADY}, 32'h0);
        end
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] expv, input string tag);
        exp_q.push_back(expv);
        xfer(1'b0, idx, 32'h0, 1'b0, tag);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input bit chk, input string tag);
        xfer(1'b1, idx, d, chk, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        tb_oe       = '1;
        tb_val      = '0;
        PRESET      = 1'b0;

        // Reset and readback
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        check("rst_pready", {31'b0, bus.PREADY}, 32'h0);
        check("rst_prdata", bus.PRDATA, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("rst_reg%0d", i));
        tb_val = 8'h5A;
        cycles(LAT + 2);
        rd(R_IDR, 32'h5A, "pins_are_inputs");

        // Reset during the access phase aborts the write
        bus.PSEL   = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR  = {R_ODR, 2'b00};
        bus.PWDATA = 32'hFF;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        PRESET      = 1'b0;
        @(negedge PCLK);
        check("rst_abort_pready", {31'b0, bus.PREADY}, 32'h0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        PRESET      = 1'b1;
        rd(R_ODR, 32'h0, "rst_abort_odr");

        // Outputs and atomic set/clear
        tb_oe = '0;
        wr(R_CR, 32'hFFFF_FFFF, 1'b1, "wr_cr");
        rd(R_CR, 32'hFF, "cr_width_mask");
        wr(R_ODR, 32'h0F, 1'b1, "wr_odr");
        wr(R_SET, 32'h30, 1'b1, "wr_set");
        wr(R_CLR, 32'h03, 1'b1, "wr_clr");
        rd(R_ODR, 32'h3C, "odr_atomic");
        check("gpio_out", {24'b0, gpio}, 32'h3C);
        rd(R_SET, 32'h0, "set_reads0");
        rd(R_CLR, 32'h0, "clr_reads0");
        cycles(LAT + 1);
        rd(R_IDR, 32'h3C, "idr_loopback");

        // Input synchroniser latency
        wr(R_CR, 32'h0, 1'b0, "wr_cr0");
        tb_val = 8'h00;
        tb_oe  = '1;
        cycles(LAT + 2);
        rd(R_IDR, 32'h00, "idr_before");
        tb_val = 8'hA5;
        rd(R_IDR, 32'h00, "idr_early");
        cycles(LAT);
        rd(R_IDR, 32'hA5, "idr_after");

        // Edge interrupts
        tb_val = 8'h02;
        cycles(LAT + 2);
        wr(R_IER, 32'h01, 1'b0, "wr_ier");
        wr(R_IEF, 32'h02, 1'b0, "wr_ief");
        rd(R_ISR, 32'h00, "isr_quiet");
        tb_val = 8'h01;
        cycles(LAT + 2);
        rd(R_ISR, 32'h03, "isr_edges");
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(R_IER, 32'h00, 1'b0, "wr_ier0");
        rd(R_ISR, 32'h03, "isr_kept_by_ier");
        wr(R_IER, 32'h01, 1'b0, "wr_ier1");
        wr(R_ISR, 32'h01, 1'b0, "w1c_bit0");
        rd(R_ISR, 32'h02, "isr_after_w1c0");
        wr(R_ISR, 32'h02, 1'b0, "w1c_bit1");
        check("irq_lag", {31'b0, irq}, 32'h1);
        @(negedge PCLK);
        check("irq_clear", {31'b0, irq}, 32'h0);
        rd(R_ISR, 32'h00, "isr_empty");

        // W1C colliding with a new rising edge on the same bit
        tb_val = 8'h00;
        cycles(LAT + 2);
        rd(R_ISR, 32'h00, "isr_fall_ignored");
        tb_val = 8'h01;
        cycles(LAT - 1);
        wr(R_ISR, 32'h01, 1'b0, "w1c_collide");
        rd(R_ISR, 32'h01, "isr_set_wins");
        check("irq_collide", {31'b0, irq}, 32'h1);

`ifdef APB_GPIO_DEBOUNCE_EN
        // Debounce: short glitch filtered, long pulse accepted
        wr(R_ISR, 32'hFF, 1'b0, "w1c_all");
        wr(R_IER, 32'h04, 1'b0, "wr_ier_pin2");
        tb_val = 8'h05;
        cycles(3);
        tb_val = 8'h01;
        cycles(12);
        rd(R_IDR, 32'h01, "deb_glitch_idr");
        rd(R_ISR, 32'h00, "deb_glitch_isr");
        tb_val = 8'h05;
        cycles(LAT - 2);
        rd(R_IDR, 32'h01, "deb_not_yet");
        rd(R_IDR, 32'h05, "deb_accepted");
        rd(R_ISR, 32'h04, "deb_isr");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
